// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the ROM arbiter: FSM state encoding, chip-enable levels,
// bus widths and the block's active-low reset level.
package rom_arbiter_pkg;

  localparam int RomAddrBus = 17;
  localparam int InstBus    = 32;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic RstEnableN  = 1'b0;

  localparam logic [InstBus-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbIssue = 2'd1,
    ArbResp  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rom_arb_pick.sv
// Winner select for a fresh grant out of IDLE. ROM_ARB_RR_EN selects round-robin
// on contention; otherwise port 0 always wins contention.
module rom_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic any,
  output logic win
);

  assign any = req0 | req1;

`ifdef ROM_ARB_RR_EN
  // On contention give the port that was not granted most recently.
  assign win = (req0 && req1) ? ~last : req1;
`else
  logic unused_last;
  assign unused_last = last;
  assign win = ~req0;
`endif

endmodule

// File: rtl/rom_arbiter.sv
// Two-port arbiter/sequencer in front of the single-ported instruction ROM driver.
// Optional round-robin contention policy is enabled with ROM_ARB_RR_EN.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int ADDR_W = RomAddrBus,
  parameter int DATA_W = InstBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst,
  input  logic              rom_ack
);

  arb_state_e        state, state_n;
  logic              grant, grant_n;
  logic              last, last_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic              pick_any, pick_win;
  logic              other_req;

  rom_arb_pick u_pick (
    .req0 (m0_req),
    .req1 (m1_req),
    .last (last),
    .any  (pick_any),
    .win  (pick_win)
  );

  assign other_req = grant ? m0_req : m1_req;

  always_ff @(posedge clk) begin
    if (rst == RstEnableN) begin
      state <= ArbIdle;
      grant <= 1'b0;
      last  <= 1'b1;
      addr  <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      last  <= last_n;
      addr  <= addr_n;
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    last_n  = last;
    addr_n  = addr;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    case (state)
      ArbIdle: begin
        if (pick_any) begin
          grant_n = pick_win;
          last_n  = pick_win;
          addr_n  = pick_win ? m1_addr : m0_addr;
          state_n = ArbIssue;
        end
      end
      ArbIssue: state_n = ArbResp;
      ArbResp: begin
        if (rom_ack) begin
          m0_ack = ~grant;
          m1_ack = grant;
          // The just-served port is masked; only the other port can take over directly.
          if (other_req) begin
            grant_n = ~grant;
            last_n  = ~grant;
            addr_n  = grant ? m0_addr : m1_addr;
            state_n = ArbIssue;
          end else begin
            state_n = ArbIdle;
          end
        end
      end
      default: state_n = ArbIdle;
    endcase
  end

  assign rom_ce   = (state != ArbIdle) ? ChipEnable : ChipDisable;
  assign rom_addr = addr;
  assign m0_rdata = m0_ack ? rom_inst : '0;
  assign m1_rdata = m1_ack ? rom_inst : '0;

endmodule

// File: tb/tb_rom_arbiter.sv
// Randomized and directed bench for rom_arbiter against a transaction-phase reference model.
module tb_rom_arbiter;

  localparam int AW = 17;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m1_req;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_ack, m1_ack;
  logic          rom_ce;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_inst;
  logic          rom_ack;

  always #5 clk = ~clk;

  rom_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .m0_req   (m0_req),
    .m0_addr  (m0_addr),
    .m0_rdata (m0_rdata),
    .m0_ack   (m0_ack),
    .m1_req   (m1_req),
    .m1_addr  (m1_addr),
    .m1_rdata (m1_rdata),
    .m1_ack   (m1_ack),
    .rom_ce   (rom_ce),
    .rom_addr (rom_addr),
    .rom_inst (rom_inst),
    .rom_ack  (rom_ack)
  );

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    logic [31:0] x;
    if (a == 17'h00010) return 32'h34011100;
    x = {15'd0, a};
    return (x * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // ROM stand-in: registered read, data valid the cycle after ce+addr.
  always @(posedge clk) if (rom_ce) rom_inst <= word(rom_addr);

  int n_err = 0;
  int n_chk = 0;

  bit            r[2];
  logic [AW-1:0] a[2];
  bit            rack, rstv;

  // Model: is an access in flight, which port owns it, has the issue cycle passed,
  // who was granted last, and which address the ROM was last pointed at.
  bit            busy, issued, gnt, last_g;
  logic [AW-1:0] lat_addr;
  bit            e_ack[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    busy = 1'b0; issued = 1'b0; gnt = 1'b0; last_g = 1'b1; lat_addr = '0;
  endtask

  task automatic step();
    bit w;
    @(negedge clk);
    rst = rstv; m0_req = r[0]; m1_req = r[1];
    m0_addr = a[0]; m1_addr = a[1]; rom_ack = rack;
    #1;
    e_ack[0] = busy && issued && rack && !gnt;
    e_ack[1] = busy && issued && rack && gnt;
    check("rom_ce", {31'd0, rom_ce}, {31'd0, busy});
    check("rom_addr", {15'd0, rom_addr}, {15'd0, lat_addr});
    check("m0_ack", {31'd0, m0_ack}, {31'd0, e_ack[0]});
    check("m1_ack", {31'd0, m1_ack}, {31'd0, e_ack[1]});
    check("m0_rdata", m0_rdata, e_ack[0] ? word(a[0]) : 32'd0);
    check("m1_rdata", m1_rdata, e_ack[1] ? word(a[1]) : 32'd0);
    if (!rstv) begin
      model_reset();
    end else if (!busy) begin
      if (r[0] || r[1]) begin
`ifdef ROM_ARB_RR_EN
        w = (r[0] && r[1]) ? !last_g : r[1];
`else
        w = (r[0] && r[1]) ? 1'b0 : r[1];
`endif
        busy = 1'b1; issued = 1'b0; gnt = w; last_g = w; lat_addr = a[w];
      end
    end else if (!issued) begin
      issued = 1'b1;
    end else if (rack) begin
      if (r[!gnt]) begin
        gnt = !gnt; last_g = gnt; issued = 1'b0; lat_addr = a[gnt];
      end else begin
        busy = 1'b0;
      end
    end
  endtask

  // Step n cycles, each requester dropping its request once served.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      for (int p = 0; p < 2; p++) if (e_ack[p]) r[p] = 1'b0;
    end
  endtask

  initial begin
    r[0] = 0; r[1] = 0; a[0] = '0; a[1] = '0; rack = 1'b1; rstv = 1'b1;
    rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0; m0_addr = '0; m1_addr = '0; rom_ack = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();

    run(2);

    // Single read on port 0
    a[0] = 17'h00010; r[0] = 1;
    run(4);

    // Contention from reset state
    a[0] = 17'h00004; a[1] = 17'h00020; r[0] = 1; r[1] = 1;
    run(6);

    // ROM wait states
    a[1] = 17'h00030; r[1] = 1;
    step(); step();
    rack = 1'b0;
    repeat (3) step();
    rack = 1'b1;
    run(3);

    // Same port back to back
    a[0] = 17'h00008; r[0] = 1;
    repeat (3) step();
    a[0] = 17'h0000C;
    repeat (3) step();
    r[0] = 0;
    run(2);

    // Persistent contention
    a[0] = 17'h00100; a[1] = 17'h00200; r[0] = 1; r[1] = 1;
    repeat (10) begin
      step();
      for (int p = 0; p < 2; p++) if (e_ack[p]) a[p] = a[p] + 17'd1;
    end
    run(8);

    // Reset while in RESP
    a[0] = 17'h00040; r[0] = 1;
    step(); step();
    rack = 1'b0; rstv = 1'b0; r[0] = 0;
    step();
    rstv = 1'b1; rack = 1'b1;
    run(4);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rack = ($urandom_range(0, 3) != 0);
      rstv = ($urandom_range(0, 249) != 0);
      step();
      for (int p = 0; p < 2; p++) begin
        if (e_ack[p]) begin
          if ($urandom_range(0, 1) == 0) r[p] = 1'b0;
          else a[p] = AW'($urandom);
        end else if (!r[p] && $urandom_range(0, 2) == 0) begin
          r[p] = 1'b1;
          a[p] = AW'($urandom);
        end
      end
    end
    rstv = 1'b1; rack = 1'b1; r[0] = 0; r[1] = 0;
    run(6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter and sequencer for the single-ported instruction ROM driver (registered read, one-cycle data latency, `ack` output). Port 0 is the CPU instruction-fetch requester; port 1 is a secondary reader (data-side ROM load or debug/boot reader). The block grants one requester at a time, drives the ROM chip enable and address, waits for ROM `ack`, and returns the word with a one-cycle acknowledge pulse. It sits between the requesters and the ROM driver in the SoC top level.

## Interface
- ADDR_W, 17, ROM word address width (matches `RomAddrBus`)
- DATA_W, 32, instruction/data width (matches `InstBus`)

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-low (0 = reset)
- m0_req  in  1  port 0 read request; held high with stable m0_addr until m0_ack
- m0_addr  in  ADDR_W  port 0 word address
- m0_rdata  out  DATA_W  port 0 read data; valid only while m0_ack=1, else 0
- m0_ack  out  1  port 0 one-cycle completion pulse
- m1_req, m1_addr, m1_rdata, m1_ack  same as port 0, for port 1
- rom_ce  out  1  ROM chip enable (`ChipEnable`/`ChipDisable`)
- rom_addr  out  ADDR_W  ROM address
- rom_inst  in  DATA_W  ROM read data (registered in ROM, valid the cycle after ce+addr)
- rom_ack  in  1  ROM data-valid qualifier

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: rom_ce=0. If any req high, pick winner, latch its address into rom_addr, record grant, go ISSUE. Else stay.
- ISSUE: rom_ce=1, rom_addr = latched address. Always go RESP.
- RESP: rom_ce=1, rom_addr held. If rom_ack=0: stay RESP, no ack (ROM re-reads same address each cycle). If rom_ack=1: assert granted port's ack for this cycle, its rdata = rom_inst; then:
  - non-granted port req high -> grant it, latch its address, go ISSUE;
  - else -> IDLE.
- The granted port's req is masked in its own ack cycle; its next request is sampled in the following cycle (IDLE). Requesters need not compute the next address combinationally from ack.
- rdata of non-acked port is forced to 0.
- Grant pointer `last`: records port granted most recently; updated at every grant.
- Reset (rst=0 at a rising edge, any state): state->IDLE, rom_ce=0, rom_addr=0, m0_ack=m1_ack=0, rdata=0, last=1 (port 0 wins first contention). In-flight access is dropped; no ack issued for it.

## Timing
- Uncontended: req sampled high in IDLE at cycle N -> ISSUE at N+1 -> ack at N+2 (latency 2, with rom_ack=1).
- Same-port back-to-back: ack at N+2, IDLE at N+3 samples req, next ack at N+5 (one access per 3 cycles).
- Alternating ports under contention: RESP->ISSUE directly, one access per 2 cycles.
- rom_ack low for k cycles in RESP extends latency by k.
- Outputs m*_ack, m*_rdata combinational from state, grant and rom_inst/rom_ack; rom_ce, rom_addr registered-state driven, no combinational path from req.

## Configuration
- ROM_ARB_RR_EN defined: IDLE contention (both req) grants port opposite to `last` (round-robin).
- Undefined: IDLE contention always grants port 0 (fixed priority). RESP hand-off to the other port and own-port masking unchanged in both builds.

## Structure
- Shared defines file: state encodings (ArbIdle, ArbIssue, ArbResp), `ChipEnable`/`ChipDisable`, `RomAddrBus`, `InstBus`, `ZeroWord`, new `RstEnableN` = 1'b0 for this block's reset.
- One sub-module: rom_arb_pick — combinational winner select from m0_req, m1_req, last (policy per ROM_ARB_RR_EN).

## Test plan
- Reset: hold rst=0 during active RESP -> next cycle IDLE, rom_ce=0, rom_addr=0, acks 0, no spurious ack after release.
- Single read: m0_req=1, m0_addr=0x00010, rom_inst=0x34011100 -> rom_ce=1 at N+1, m0_ack=1 and m0_rdata=0x34011100 at N+2, m1_ack stays 0.
- Contention from reset: both req at N (addr 0x00004 / 0x00020) -> m0_ack at N+2, ISSUE for port 1 at N+3, m1_ack at N+4 with rom_addr=0x00020.
- Persistent contention: both req held 10 cycles -> RR build alternates 0,1,0,1 acks every 2 cycles; fixed build also alternates (hand-off) but after IDLE gap both-req picks port 0.
- ROM wait: rom_ack=0 for 3 cycles in RESP -> ack at N+5, rom_ce/rom_addr stable throughout.
- Back-to-back same port: m0_req held, addr changes 0x8->0xC after ack -> acks at N+2, N+5 with correct words.
